relu_maxpool_requant: RTL and testbench
=======================================

Name: relu_maxpool_requant

Overview:
Downstream stage of the convolution engine. Consumes the engine's raster-ordered 32-bit convolution results, one per valid beat. Applies bias and ReLU, then 2x2 stride-2 max-pooling, then requantizes to signed int8. Emits the pooled map as an address/data/write-enable stream, in the same form as the engine's BRAM write port, for storage or for the next layer's pixel stream.

Parameters:
IN_SIZE, 28, side of the incoming square map (MAPSIZE-4 of the engine); must be even, odd is an elaboration error
SHIFT, 8, arithmetic right shift applied at requantization (0..31)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin a frame; sampled only in IDLE
data_valid_in  in  1  data_in carries a valid sample this cycle
data_in  in  32 signed  convolution result, raster order
bias  in  32 signed  per-map bias, held constant during a frame
out_addr  out  $clog2((IN_SIZE/2)**2)  pooled pixel index, raster order
pixel_out  out  8 signed  pooled, requantized pixel
pixel_valid_out  out  1  out_addr/pixel_out valid this cycle
all_done  out  1  one-cycle pulse when the frame is complete

Behaviour:
- Reset (async assert, sync release): state=IDLE. out_addr=0, pixel_out=0, pixel_valid_out=0, all_done=0. All counters and pipeline valids are 0.
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 -> RUN, and clear row/col/out_addr counters. data_valid_in is ignored.
  - RUN: each data_valid_in=1 cycle accepts one sample. Gaps stall with no timeout. start is ignored.
  - Accepting the sample at row=col=IN_SIZE-1 -> DRAIN.
  - DRAIN: wait until the pipeline is empty -> DONE.
  - DONE: all_done=1 for one cycle, then -> IDLE.
- Counters: col counts 0..IN_SIZE-1 and wraps to 0, incrementing row. row counts 0..IN_SIZE-1.
- Stage 1 (registered): v = sat32(data_in + bias), saturating to [-2^31, 2^31-1]. r = (v<0) ? 0 : v.
- Stage 2 (registered): max-pool.
  - Even col: hold h=r.
  - Odd col, even row: partial[col/2] = max(h, r).
  - Odd col, odd row: m = max(h, r, partial[col/2]). Compute q = (m + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, using a 33-bit intermediate. pixel_out = min(q, 127); it is never negative. Assert pixel_valid_out and write out_addr.
  - out_addr increments after each emitted pixel.
- Latency: pixel_valid_out is high for exactly one cycle, in the cycle after the 2nd rising edge following acceptance of the window's last sample (odd row, odd col). Outputs are not back-pressured.
- all_done pulses the cycle after the final pixel_valid_out, i.e. after (IN_SIZE/2)^2 emitted pixels.
- pixel_out and out_addr hold their last values when pixel_valid_out=0.
- partial buffer: IN_SIZE/2 entries x 32 bits. Each entry is written on an even row before it is read on the next odd row. No reset of contents is required.
- Reset mid-frame: the frame is abandoned, no further outputs, state=IDLE. A new start begins cleanly at out_addr=0.
- A data_valid_in beat arriving in DRAIN/DONE is dropped. Upstream contract: exactly IN_SIZE^2 beats per frame.

Decomposition:
- Package pool_pkg:
  - state_t enum (IDLE, RUN, DRAIN, DONE)
  - function sat_add32 (signed 32+32 -> saturated 32)
  - function requant_u8 (value, shift -> 0..127)
  - localparam INT8_MAX=127
- Sub-module pool_row_buffer (IN_SIZE/2 x 32 register array):
  - ports: clk, wr_en, wr_idx, wr_data, rd_idx, rd_data
  - combinational read
- Top holds the FSM, counters, stage registers and max/requant datapath.

Test Plan:
1. IN_SIZE=4, SHIFT=0, bias=0, data_in=0..15 back-to-back -> pixel_out 5,7,13,15 at out_addr 0,1,2,3. Each pixel appears 2 edges after samples 5,7,13,15 respectively; all_done one cycle after the last.
2. IN_SIZE=4, SHIFT=0, bias=0, all data_in=-100 -> four outputs, all 0. Then with bias=+150 and the same data -> all 50.
3. IN_SIZE=4, SHIFT=8, data_in all 32767 -> (32767+128)>>8=128 -> saturated 127.
   Same settings, SHIFT=1, data_in all 3 -> 2 (rounding).
4. IN_SIZE=4, data_in=0x7FFFFFF0, bias=0x100, SHIFT=0 -> sum saturates to 0x7FFFFFFF, pixel_out=127.
   data_in=0x80000000, bias=-1 -> saturates negative, ReLU gives 0.
5. Scenario 1 data with data_valid_in asserted every other cycle plus random 0..5-cycle gaps -> identical pixel/address sequence, single all_done.
6. IN_SIZE=28 (default): assert rst asynchronously mid-cycle after 40 samples. Outputs drop to 0 immediately. Then start and a full random frame -> 196 outputs matching a golden model, out_addr 0..195, one all_done.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and arithmetic helpers for the bias/ReLU/max-pool/requant stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pool_pkg;

    localparam int INT8_MAX = 127;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Signed 32+32 add, clamped to the int32 range instead of wrapping.
    function automatic logic signed [31:0] sat_add32(input logic signed [31:0] a,
                                                     input logic signed [31:0] b);
        logic signed [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31]) begin
            return s[32] ? 32'sh8000_0000 : 32'sh7fff_ffff;
        end
        return s[31:0];
    endfunction

    function automatic logic signed [31:0] max_s32(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
        return (a > b) ? a : b;
    endfunction

    // Round-half-up arithmetic shift, clipped to 0..127. Input is post-ReLU so
    // never negative; 33 bits keep the rounding add from overflowing.
    function automatic logic signed [7:0] requant_u8(input logic signed [31:0] value,
                                                     input logic [4:0] shift);
        logic signed [32:0] rnd;
        logic signed [32:0] acc;
        rnd = (shift == 5'd0) ? 33'sd0 : (33'sd1 <<< (shift - 5'd1));
        acc = {value[31], value} + rnd;
        acc = acc >>> shift;
        if (acc > $signed(33'(INT8_MAX))) begin
            return 8'(INT8_MAX);
        end
        return acc[7:0];
    endfunction

endpackage

// File: rtl/pool_row_buffer.sv
// Holds one pooled-row of horizontal maxima from the even input row.
// Latency: write takes effect next edge; read is combinational.
// Backpressure: none, written/read once per odd-column sample.
module pool_row_buffer #(
    parameter int DEPTH = 14,
    parameter int IDX_W = 4
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic signed [31:0]      wr_data,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic signed [31:0]      rd_data
);

    logic signed [31:0] mem [DEPTH];

    // Contents need no reset: every entry is written on the even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/relu_maxpool_requant.sv
// Bias + ReLU, 2x2 stride-2 max-pool and int8 requant of a raster conv result stream.
// Latency: pixel valid in the cycle after the 2nd edge following the window's last sample.
// Backpressure: none; input gaps stall, outputs are never held off.
module relu_maxpool_requant
    import pool_pkg::*;
#(
    parameter int IN_SIZE = 28,
    parameter int SHIFT   = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   data_valid_in,
    input  logic signed [31:0]                     data_in,
    input  logic signed [31:0]                     bias,
    output logic [$clog2((IN_SIZE/2)**2)-1:0]      out_addr,
    output logic signed [7:0]                      pixel_out,
    output logic                                   pixel_valid_out,
    output logic                                   all_done
);

    localparam int HALF   = IN_SIZE / 2;
    localparam int CNT_W  = $clog2(IN_SIZE);
    localparam int IDX_W  = CNT_W - 1;
    localparam int ADDR_W = $clog2((IN_SIZE/2)**2);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(IN_SIZE - 1);
    localparam logic [4:0]       SHIFT_AMT = 5'(SHIFT);

    if ((IN_SIZE % 2) != 0 || IN_SIZE < 4) begin : g_bad_size
        $error("relu_maxpool_requant: IN_SIZE must be even and >= 4");
    end
    if (SHIFT < 0 || SHIFT > 31) begin : g_bad_shift
        $error("relu_maxpool_requant: SHIFT must be 0..31");
    end

    state_t state, state_nxt;

    logic [CNT_W-1:0]  row, col;
    logic [ADDR_W-1:0] addr_cnt;
    logic              accept, last_sample;

    // Stage 1 registers: rectified sample plus its window position.
    logic               s1_vld;
    logic signed [31:0] s1_r;
    logic               s1_col_odd, s1_row_odd;
    logic [IDX_W-1:0]   s1_idx;

    // Stage 2 datapath.
    logic signed [31:0] h;
    logic signed [31:0] pair_max, part_rd, win_max;
    logic               buf_wr, emit;

    assign accept      = (state == RUN) && data_valid_in;
    assign last_sample = accept && (row == LAST) && (col == LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and done pulse.
    always_comb begin
        state_nxt = state;
        all_done  = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN:   if (last_sample) state_nxt = DRAIN;
            DRAIN: if (!s1_vld) state_nxt = DONE;
            DONE: begin
                all_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Raster position of the next accepted sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (state == IDLE && start) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (col == LAST) begin
                col <= '0;
                row <= (row == LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Stage 1: saturating bias add then ReLU, tagged with window position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld     <= 1'b0;
            s1_r       <= '0;
            s1_col_odd <= 1'b0;
            s1_row_odd <= 1'b0;
            s1_idx     <= '0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_r       <= max_s32(sat_add32(data_in, bias), 32'sd0);
                s1_col_odd <= col[0];
                s1_row_odd <= row[0];
                s1_idx     <= col[CNT_W-1:1];
            end
        end
    end

    assign pair_max = max_s32(h, s1_r);
    assign win_max  = max_s32(pair_max, part_rd);
    assign buf_wr   = s1_vld && s1_col_odd && !s1_row_odd;
    assign emit     = s1_vld && s1_col_odd && s1_row_odd;

    pool_row_buffer #(
        .DEPTH (HALF),
        .IDX_W (IDX_W)
    ) u_row_buf (
        .clk     (clk),
        .wr_en   (buf_wr),
        .wr_idx  (s1_idx),
        .wr_data (pair_max),
        .rd_idx  (s1_idx),
        .rd_data (part_rd)
    );

    // Stage 2: hold even-column value, emit requantized window max on odd row/col.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h               <= '0;
            pixel_out       <= '0;
            pixel_valid_out <= 1'b0;
            out_addr        <= '0;
            addr_cnt        <= '0;
        end else begin
            pixel_valid_out <= emit;
            if (s1_vld && !s1_col_odd) begin
                h <= s1_r;
            end
            if (state == IDLE && start) begin
                addr_cnt <= '0;
                out_addr <= '0;
            end else if (emit) begin
                pixel_out <= requant_u8(win_max, SHIFT_AMT);
                out_addr  <= addr_cnt;
                addr_cnt  <= addr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_relu_maxpool_requant.sv
// Directed bench for relu_maxpool_requant across several IN_SIZE/SHIFT builds.
// Latency: checks each pixel lands exactly two cycles after its window's last sample.
// Backpressure: exercises input gaps; outputs are free-running.
module tb_relu_maxpool_requant;

    logic               clk;
    logic               rst;
    logic [3:0]         start_v;
    logic               dv;
    logic signed [31:0] din;
    logic signed [31:0] bias;

    logic [1:0]         a0, a1, a2;
    logic [7:0]         a3;
    logic signed [7:0]  p0, p1, p2, p3;
    logic               v0, v1, v2, v3;
    logic               d0, d1, d2, d3;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int sel    = 0;

    int stim[$];
    int exp_pix[$];
    int exp_cyc[$];
    int got_pix[$];
    int got_addr[$];
    int got_cyc[$];
    int done_cnt;
    int done_cyc;

    logic               m_pv, m_done;
    logic signed [7:0]  m_pix;
    int                 m_addr;

    relu_maxpool_requant #(.IN_SIZE(4), .SHIFT(0)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .data_valid_in(dv), .data_in(din),
        .bias(bias), .out_addr(a0), .pixel_out(p0), .pixel_valid_out(v0), .all_done(d0));
    relu_maxpool_requant #(.IN_SIZE(4), .SHIFT(8)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .data_valid_in(dv), .data_in(din),
        .bias(bias), .out_addr(a1), .pixel_out(p1), .pixel_valid_out(v1), .all_done(d1));
    relu_maxpool_requant #(.IN_SIZE(4), .SHIFT(1)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .data_valid_in(dv), .data_in(din),
        .bias(bias), .out_addr(a2), .pixel_out(p2), .pixel_valid_out(v2), .all_done(d2));
    relu_maxpool_requant #(.IN_SIZE(28), .SHIFT(8)) u3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .data_valid_in(dv), .data_in(din),
        .bias(bias), .out_addr(a3), .pixel_out(p3), .pixel_valid_out(v3), .all_done(d3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Route the instance under test to the monitor.
    always_comb begin
        m_pv = v0; m_done = d0; m_pix = p0; m_addr = int'(a0);
        case (sel)
            1: begin m_pv = v1; m_done = d1; m_pix = p1; m_addr = int'(a1); end
            2: begin m_pv = v2; m_done = d2; m_pix = p2; m_addr = int'(a2); end
            3: begin m_pv = v3; m_done = d3; m_pix = p3; m_addr = int'(a3); end
            default: ;
        endcase
    end

    // Collect output beats away from the active edge.
    always @(negedge clk) begin
        if (m_pv) begin
            got_pix.push_back(int'(m_pix));
            got_addr.push_back(m_addr);
            got_cyc.push_back(cyc);
        end
        if (m_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill(input int n, input int val);
        stim.delete();
        for (int i = 0; i < n * n; i++) stim.push_back(val);
    endtask

    task automatic set_exp4(input int e0, input int e1, input int e2, input int e3);
        exp_pix.delete();
        exp_pix.push_back(e0); exp_pix.push_back(e1);
        exp_pix.push_back(e2); exp_pix.push_back(e3);
    endtask

    // Independent reference: 64-bit math over each 2x2 window.
    task automatic model(input int n, input int sh, input int b);
        longint v, m, q, rnd;
        exp_pix.delete();
        rnd = (sh > 0) ? (longint'(1) << (sh - 1)) : 0;
        for (int pr = 0; pr < n / 2; pr++) begin
            for (int pc = 0; pc < n / 2; pc++) begin
                m = 0;
                for (int dy = 0; dy < 2; dy++) begin
                    for (int dx = 0; dx < 2; dx++) begin
                        v = longint'(stim[(2 * pr + dy) * n + 2 * pc + dx]) + longint'(b);
                        if (v > 64'sd2147483647) v = 64'sd2147483647;
                        if (v < -64'sd2147483648) v = -64'sd2147483648;
                        if (v < 0) v = 0;
                        if (v > m) m = v;
                    end
                end
                q = (m + rnd) >>> sh;
                if (q > 127) q = 127;
                exp_pix.push_back(int'(q));
            end
        end
    endtask

    task automatic run_frame(input string name, input int s, input int n, input int gaps);
        got_pix.delete(); got_addr.delete(); got_cyc.delete(); exp_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
        sel = s;
        @(posedge clk); #1;
        start_v[s] = 1'b1;
        @(posedge clk); #1;
        start_v = '0;
        for (int i = 0; i < n * n; i++) begin
            if (gaps != 0) begin
                repeat (1 + $urandom_range(0, 5)) begin
                    dv = 1'b0;
                    @(posedge clk); #1;
                end
            end
            dv  = 1'b1;
            din = stim[i];
            if (((i / n) % 2 == 1) && ((i % n) % 2 == 1)) exp_cyc.push_back(cyc + 2);
            @(posedge clk); #1;
        end
        dv = 1'b0;
        for (int w = 0; w < 50 && done_cnt == 0; w++) begin
            @(posedge clk); #1;
        end
        repeat (6) @(posedge clk);
        #1;
        chk({name, "_npix"}, got_pix.size(), exp_pix.size());
        for (int k = 0; k < exp_pix.size() && k < got_pix.size(); k++) begin
            chk($sformatf("%s_pix%0d", name, k), got_pix[k], exp_pix[k]);
            chk($sformatf("%s_addr%0d", name, k), got_addr[k], k);
            chk($sformatf("%s_lat%0d", name, k), got_cyc[k], exp_cyc[k]);
        end
        chk({name, "_done_cnt"}, done_cnt, 1);
        chk({name, "_done_cyc"}, done_cyc, exp_cyc[exp_cyc.size() - 1] + 1);
    endtask

    initial begin
        rst = 1'b1; dv = 1'b0; din = '0; bias = '0; start_v = '0;
        #12;
        chk("rst_addr0", int'(a0), 0);
        chk("rst_pix0", int'(p0), 0);
        chk("rst_vld0", int'(v0), 0);
        chk("rst_done0", int'(d0), 0);
        chk("rst_addr3", int'(a3), 0);
        chk("rst_vld3", int'(v3), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Ramp 0..15: window maxima are 5,7,13,15.
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(i);
        bias = 0;
        set_exp4(5, 7, 13, 15);
        run_frame("ramp", 0, 4, 0);

        // Negative inputs clipped by ReLU, then lifted by bias.
        fill(4, -100); bias = 0; set_exp4(0, 0, 0, 0);
        run_frame("neg", 0, 4, 0);
        bias = 150; set_exp4(50, 50, 50, 50);
        run_frame("bias", 0, 4, 0);

        // Requant clip at 127 and rounding.
        fill(4, 32767); bias = 0; set_exp4(127, 127, 127, 127);
        run_frame("clip", 1, 4, 0);
        fill(4, 3); set_exp4(2, 2, 2, 2);
        run_frame("round", 2, 4, 0);

        // Bias add saturation at both rails.
        fill(4, 32'h7FFF_FFF0); bias = 32'sh100; set_exp4(127, 127, 127, 127);
        run_frame("satpos", 0, 4, 0);
        fill(4, 32'h8000_0000); bias = -1; set_exp4(0, 0, 0, 0);
        run_frame("satneg", 0, 4, 0);

        // Ramp again with stalled input.
        stim.delete();
        for (int i = 0; i < 16; i++) stim.push_back(i);
        bias = 0;
        set_exp4(5, 7, 13, 15);
        run_frame("gaps", 0, 4, 1);

        // Abandon a 28x28 frame mid-row with an async reset.
        sel = 3;
        bias = 0;
        @(posedge clk); #1;
        start_v[3] = 1'b1;
        @(posedge clk); #1;
        start_v = '0;
        for (int i = 0; i < 40; i++) begin
            dv  = 1'b1;
            din = 1000 * (i + 1);
            @(posedge clk); #1;
        end
        dv = 1'b0;
        chk("pre_rst_addr", int'(a3), 4);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_addr", int'(a3), 0);
        chk("midrst_pix", int'(p3), 0);
        chk("midrst_vld", int'(v3), 0);
        chk("midrst_done", int'(d3), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full random frame after the reset.
        stim.delete();
        for (int i = 0; i < 28 * 28; i++) stim.push_back(int'($urandom_range(0, 60000)) - 20000);
        bias = -500;
        model(28, 8, -500);
        run_frame("full", 3, 28, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
